// File: rtl/program_sequencer.sv
// Program sequencer: loads host instruction words into program memory (stage 00),
// then steps FETCH/DECODE/EXECUTE (01/10/11) with halt, restart and an executed-instruction counter.
// Ports: clk/rst_n; load_start/run_start/halt_req commands; load_valid/load_data/load_last/load_ready
// host handshake; stage/core_en to control logic; pmem_we/pmem_addr/pmem_wdata write port;
// prog_len/load_full/running/instr_count status.
module program_sequencer #(
  parameter int PROG_DEPTH = 256,
  parameter int ADDR_W     = 8,
  parameter int INSTR_W    = 12,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic               run_start,
  input  logic               halt_req,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic [1:0]         stage,
  output logic               core_en,
  output logic               pmem_we,
  output logic [ADDR_W-1:0]  pmem_addr,
  output logic [INSTR_W-1:0] pmem_wdata,
  output logic [ADDR_W:0]    prog_len,
  output logic               load_full,
  output logic               running,
  output logic [CNT_W-1:0]   instr_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [1:0] ST_LOAD    = 2'b00;
  localparam logic [1:0] ST_FETCH   = 2'b01;
  localparam logic [1:0] ST_DECODE  = 2'b10;
  localparam logic [1:0] ST_EXECUTE = 2'b11;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(PROG_DEPTH);

  logic [1:0]      state;
  // One bit wider than the memory address so "all PROG_DEPTH slots used" is representable.
  logic [ADDR_W:0] wr_addr;
  // Set once the final beat is accepted; holds LOAD for the cycle its write issues.
  logic            load_done;
  logic            halt_lat;
  logic            accept;
  logic            last_slot;

  assign load_ready = (state == S_LOAD) && !load_done && (wr_addr < DEPTH);
  assign accept     = load_valid && load_ready;
  assign last_slot  = (wr_addr == DEPTH - 1'b1);
  assign core_en    = (state != S_IDLE);
  assign running    = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      stage       <= ST_LOAD;
      wr_addr     <= '0;
      load_done   <= 1'b0;
      halt_lat    <= 1'b0;
      pmem_we     <= 1'b0;
      pmem_addr   <= '0;
      pmem_wdata  <= '0;
      prog_len    <= '0;
      load_full   <= 1'b0;
      instr_count <= '0;
    end else begin
      // Write port is a one-cycle registered copy of the accepted beat.
      pmem_we <= accept;
      if (accept) begin
        pmem_addr  <= wr_addr[ADDR_W-1:0];
        pmem_wdata <= load_data;
      end

      case (state)
        S_IDLE: begin
          // stage is left untouched here so the control logic sees its last value.
          if (load_start) begin
            state     <= S_LOAD;
            stage     <= ST_LOAD;
            wr_addr   <= '0;
            load_full <= 1'b0;
            load_done <= 1'b0;
          end else if (run_start && (prog_len != '0)) begin
            state    <= S_RUN;
            stage    <= ST_FETCH;
            halt_lat <= 1'b0;
          end
        end

        S_LOAD: begin
          if (load_done) begin
            state <= S_IDLE;
          end else if (accept) begin
            wr_addr <= wr_addr + 1'b1;
            if (load_last || last_slot) begin
              prog_len  <= wr_addr + 1'b1;
              load_full <= !load_last;
              load_done <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (halt_req) halt_lat <= 1'b1;
          case (stage)
            ST_FETCH:  stage <= ST_DECODE;
            ST_DECODE: stage <= ST_EXECUTE;
            ST_EXECUTE: begin
              if (!(&instr_count)) instr_count <= instr_count + 1'b1;
              // A halt seen in this same EXECUTE cycle still stops here.
              if (halt_lat || halt_req) begin
                state    <= S_IDLE;
                halt_lat <= 1'b0;
              end else begin
                stage <= ST_FETCH;
              end
            end
            default:   stage <= ST_FETCH;
          endcase
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
